// File: rtl/float_adder_pipe_if.sv
// Operand/result bundle for float_adder_pipe. i_sub exists only when FADD_SUB_EN is defined.
// Handshake: a beat transfers on a rising clk edge where valid && ready are both high;
// the producer holds its valid and data stable until that edge, and ready may depend on valid.
interface float_adder_pipe_if #(
  parameter int MANT_W = 15,
  parameter int EXP_W  = 5
);
  logic              i_valid;
  logic              i_ready;
  logic [MANT_W-1:0] i_mant1;
  logic [MANT_W-1:0] i_mant2;
  logic [EXP_W-1:0]  i_exp1;
  logic [EXP_W-1:0]  i_exp2;
`ifdef FADD_SUB_EN
  logic              i_sub;
`endif
  logic              o_valid;
  logic              o_ready;
  logic [MANT_W-1:0] o_mant;
  logic [EXP_W-1:0]  o_exp;
  logic              o_ovf;
  logic              o_unf;

  modport master (
`ifdef FADD_SUB_EN
    output i_sub,
`endif
    output i_valid, i_mant1, i_mant2, i_exp1, i_exp2, o_ready,
    input  i_ready, o_valid, o_mant, o_exp, o_ovf, o_unf
  );

  modport slave (
`ifdef FADD_SUB_EN
    input  i_sub,
`endif
    input  i_valid, i_mant1, i_mant2, i_exp1, i_exp2, o_ready,
    output i_ready, o_valid, o_mant, o_exp, o_ovf, o_unf
  );
endinterface

// File: rtl/float_adder_pipe.sv
// Three-stage (align, add, normalise) adder for mant * 2^exp values with valid/ready backpressure.
// Define FADD_SUB_EN to add the i_sub input (1 = op1 - op2); otherwise the block always adds.
module float_adder_pipe #(
  parameter int MANT_W = 15,
  parameter int EXP_W  = 5
) (
  input logic               clk,
  input logic               rst_n,
  float_adder_pipe_if.slave bus
);
  localparam int AW = MANT_W + 1;
  localparam int PW = EXP_W + 1;
  // Wide enough for exp + 1 and exp - (MANT_W - 1) without wrapping.
  localparam int XW = EXP_W + $clog2(MANT_W) + 2;
  localparam logic signed [XW-1:0] EMAX = XW'(2 ** (EXP_W - 1) - 1);
  localparam logic signed [XW-1:0] EMIN = XW'(-(2 ** (EXP_W - 1)));

  logic                     r_v1, r_v2, r_v3;
  logic signed [AW-1:0]     r_a1, r_b1;
  logic signed [PW-1:0]     r_e1, r_e2;
  logic signed [AW-1:0]     r_sum2;
  logic [MANT_W-1:0]        r_mant3;
  logic [EXP_W-1:0]         r_exp3;
  logic                     r_ovf3, r_unf3;

  logic                     w_en1, w_en2, w_en3;
  logic signed [AW-1:0]     w_op1, w_op2_raw, w_op2, w_a, w_b;
  logic signed [PW-1:0]     w_x1, w_x2, w_d, w_emax;
  logic [PW-1:0]            w_abs;
  logic [31:0]              w_sh;
  logic signed [XW-1:0]     w_k, w_e_ext, w_e_n;
  logic [MANT_W-1:0]        w_m_n, w_mant;
  logic [EXP_W-1:0]         w_exp;
  logic                     w_ovf, w_unf;

  // A stage may load when it is empty or its content moves on this edge.
  assign w_en3       = !r_v3 || bus.o_ready;
  assign w_en2       = !r_v2 || w_en3;
  assign w_en1       = !r_v1 || w_en2;
  assign bus.i_ready = w_en1;

  assign w_op1     = {bus.i_mant1[MANT_W-1], bus.i_mant1};
  assign w_op2_raw = {bus.i_mant2[MANT_W-1], bus.i_mant2};
`ifdef FADD_SUB_EN
  assign w_op2 = bus.i_sub ? -w_op2_raw : w_op2_raw;
`else
  assign w_op2 = w_op2_raw;
`endif

  assign w_x1   = {bus.i_exp1[EXP_W-1], bus.i_exp1};
  assign w_x2   = {bus.i_exp2[EXP_W-1], bus.i_exp2};
  assign w_d    = w_x1 - w_x2;
  assign w_abs  = w_d[PW-1] ? PW'(-w_d) : PW'(w_d);
  assign w_sh   = (32'(w_abs) > 32'(AW)) ? 32'(AW) : 32'(w_abs);
  assign w_a    = w_d[PW-1] ? (w_op1 >>> w_sh) : w_op1;
  assign w_b    = w_d[PW-1] ? w_op2 : (w_op2 >>> w_sh);
  assign w_emax = w_d[PW-1] ? w_x2 : w_x1;

  always_comb begin : normalise
    logic found;
    found   = 1'b0;
    w_k     = '0;
    for (int i = MANT_W - 2; i >= 0; i--) begin
      if (!found && (r_sum2[i] == r_sum2[MANT_W-1])) begin
        w_k = w_k + XW'(1);
      end else begin
        found = 1'b1;
      end
    end
    w_e_ext = {{(XW-PW){r_e2[PW-1]}}, r_e2};
    if (r_sum2[AW-1] != r_sum2[AW-2]) begin
      w_m_n = r_sum2[AW-1:1];
      w_e_n = w_e_ext + XW'(1);
    end else begin
      w_m_n = r_sum2[MANT_W-1:0] << w_k;
      w_e_n = w_e_ext - w_k;
    end
    w_mant = '0;
    w_exp  = '0;
    w_ovf  = 1'b0;
    w_unf  = 1'b0;
    if (r_sum2 == '0) begin
      w_mant = '0;
    end else if (w_e_n > EMAX) begin
      w_mant = r_sum2[AW-1] ? {1'b1, {(MANT_W-1){1'b0}}} : {1'b0, {(MANT_W-1){1'b1}}};
      w_exp  = EMAX[EXP_W-1:0];
      w_ovf  = 1'b1;
    end else if (w_e_n < EMIN) begin
      w_unf  = 1'b1;
    end else begin
      w_mant = w_m_n;
      w_exp  = w_e_n[EXP_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_a1 <= '0;
      r_b1 <= '0;
      r_e1 <= '0;
    end else if (w_en1) begin
      r_v1 <= bus.i_valid;
      if (bus.i_valid) begin
        r_a1 <= w_a;
        r_b1 <= w_b;
        r_e1 <= w_emax;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2   <= 1'b0;
      r_sum2 <= '0;
      r_e2   <= '0;
    end else if (w_en2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_sum2 <= r_a1 + r_b1;
        r_e2   <= r_e1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3    <= 1'b0;
      r_mant3 <= '0;
      r_exp3  <= '0;
      r_ovf3  <= 1'b0;
      r_unf3  <= 1'b0;
    end else if (w_en3) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_mant3 <= w_mant;
        r_exp3  <= w_exp;
        r_ovf3  <= w_ovf;
        r_unf3  <= w_unf;
      end
    end
  end

  assign bus.o_valid = r_v3;
  assign bus.o_mant  = r_mant3;
  assign bus.o_exp   = r_exp3;
  assign bus.o_ovf   = r_ovf3 && r_v3;
  assign bus.o_unf   = r_unf3 && r_v3;
endmodule

// File: tb/tb_float_adder_pipe.sv
// Directed bench for float_adder_pipe at MANT_W=15, EXP_W=5; results packed as {mant, exp, ovf, unf}.
module tb_float_adder_pipe;
  localparam int W = 22;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [W-1:0] exp_q[$];

  float_adder_pipe_if #(.MANT_W(15), .EXP_W(5)) bus ();

  float_adder_pipe #(.MANT_W(15), .EXP_W(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic logic [W-1:0] obs();
    return {bus.o_mant, bus.o_exp, bus.o_ovf, bus.o_unf};
  endfunction

  // Presents one operand set and returns just after the edge that accepted it.
  task automatic drive_op(input logic [14:0] m1, input logic [4:0] e1,
                          input logic [14:0] m2, input logic [4:0] e2);
    int guard;
    guard = 0;
    bus.i_valid = 1'b1;
    bus.i_mant1 = m1;
    bus.i_exp1  = e1;
    bus.i_mant2 = m2;
    bus.i_exp2  = e2;
    #1;
    while (bus.i_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      total++; bad++;
      $display("FAIL drive_timeout: i_ready=%b required 1", bus.i_ready);
    end
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.o_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({bus.o_valid, obs()} !== {1'b0, {W{1'b0}}}) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b res=%h required v=0 res=0", bus.o_valid, obs());
    end
    total++;
    if (bus.i_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_i_ready: got %b required 1", bus.i_ready);
    end
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Result is registered at the accept edge and the two following edges.
  task automatic test_latency();
    bus.o_ready = 1'b1;
    drive_op(15'h2000, 5'h01, 15'h2000, 5'h00);
    total++;
    if (bus.o_valid !== 1'b0) begin
      bad++; $display("FAIL latency_edge0: o_valid=%b required 0", bus.o_valid);
    end
    @(posedge clk); #1;
    total++;
    if (bus.o_valid !== 1'b0) begin
      bad++; $display("FAIL latency_edge1: o_valid=%b required 0", bus.o_valid);
    end
    @(posedge clk); #1;
    total++;
    if (bus.o_valid !== 1'b1) begin
      bad++; $display("FAIL latency_edge2: o_valid=%b required 1", bus.o_valid);
    end
    total++;
    if (obs() !== {15'h3000, 5'h01, 2'b00}) begin
      bad++; $display("FAIL latency_result: got %h required %h", obs(), {15'h3000, 5'h01, 2'b00});
    end
    @(posedge clk); #1;
    total++;
    if (bus.o_valid !== 1'b0) begin
      bad++; $display("FAIL latency_drain: o_valid=%b required 0", bus.o_valid);
    end
  endtask

  task automatic test_arith();
    logic [14:0] m1 [11] = '{15'h2000, 15'h3000, 15'h2000, 15'h2000, 15'h3000, 15'h4000,
                             15'h2000, 15'h2000, 15'h0003, 15'h2000, 15'h6000};
    logic [4:0]  e1 [11] = '{5'h01, 5'h00, 5'h00, 5'h03, 5'h0F, 5'h0F,
                             5'h10, 5'h0F, 5'h04, 5'h00, 5'h02};
    logic [14:0] m2 [11] = '{15'h2000, 15'h3000, 15'h6001, 15'h6000, 15'h3000, 15'h4000,
                             15'h6001, 15'h7FFF, 15'h0000, 15'h2000, 15'h0000};
    logic [4:0]  e2 [11] = '{5'h00, 5'h00, 5'h00, 5'h03, 5'h0F, 5'h0F,
                             5'h10, 5'h10, 5'h00, 5'h01, 5'h02};
    logic [W-1:0] ex [11] = '{{15'h3000, 5'h01, 2'b00}, {15'h3000, 5'h01, 2'b00},
                              {15'h2000, 5'h13, 2'b00}, {15'h0000, 5'h00, 2'b00},
                              {15'h3FFF, 5'h0F, 2'b10}, {15'h4000, 5'h0F, 2'b10},
                              {15'h0000, 5'h00, 2'b01}, {15'h3FFE, 5'h0E, 2'b00},
                              {15'h3000, 5'h18, 2'b00}, {15'h3000, 5'h01, 2'b00},
                              {15'h4000, 5'h01, 2'b00}};
    bit got;
    bus.o_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive_op(m1[i], e1[i], m2[i], e2[i]);
      wait_valid(got);
      total++;
      if (!got || obs() !== ex[i]) begin
        bad++;
        $display("FAIL arith_%0d: valid=%b got %h required %h", i, got, obs(), ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    bus.o_ready = 1'b1;
    exp_q.push_back({15'h3000, 5'h01, 2'b00});
    exp_q.push_back({15'h2000, 5'h13, 2'b00});
    exp_q.push_back({15'h3000, 5'h18, 2'b00});
    drive_op(15'h3000, 5'h00, 15'h3000, 5'h00);
    drive_op(15'h2000, 5'h00, 15'h6001, 5'h00);
    drive_op(15'h0003, 5'h04, 15'h0000, 5'h00);
    for (int i = 0; i < 3; i++) begin
      logic [W-1:0] want;
      want = exp_q.pop_front();
      total++;
      if (bus.o_valid !== 1'b1 || obs() !== want) begin
        bad++;
        $display("FAIL b2b_%0d: valid=%b got %h required %h", i, bus.o_valid, obs(), want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int got;
    bit acc;
    got = 0;
    bus.o_ready = 1'b0;
    exp_q.push_back({15'h3000, 5'h01, 2'b00});
    exp_q.push_back({15'h2000, 5'h02, 2'b00});
    exp_q.push_back({15'h2000, 5'h13, 2'b00});
    exp_q.push_back({15'h3000, 5'h18, 2'b00});
    drive_op(15'h2000, 5'h01, 15'h2000, 5'h00);
    drive_op(15'h1000, 5'h02, 15'h1000, 5'h02);
    drive_op(15'h2000, 5'h00, 15'h6001, 5'h00);
    total++;
    if (bus.i_ready !== 1'b0) begin
      bad++; $display("FAIL bp_ready_fall: i_ready=%b required 0", bus.i_ready);
    end
    bus.i_valid = 1'b1;
    bus.i_mant1 = 15'h0003; bus.i_exp1 = 5'h04;
    bus.i_mant2 = 15'h0000; bus.i_exp2 = 5'h00;
    for (int c = 0; c < 3; c++) begin
      total++;
      if ({bus.o_valid, bus.i_ready, obs()} !== {2'b10, exp_q[0]}) begin
        bad++;
        $display("FAIL bp_hold_%0d: v=%b rdy=%b got %h required v=1 rdy=0 %h",
                 c, bus.o_valid, bus.i_ready, obs(), exp_q[0]);
      end
      @(posedge clk); #1;
    end
    bus.o_ready = 1'b1;
    #1;
    total++;
    if (bus.i_ready !== 1'b1) begin
      bad++; $display("FAIL bp_no_bubble: i_ready=%b required 1", bus.i_ready);
    end
    for (int c = 0; c < 12; c++) begin
      acc = bus.i_valid && bus.i_ready;
      if (bus.o_valid === 1'b1) begin
        got++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL bp_extra: got %h required none", obs());
        end else if (obs() !== exp_q[0]) begin
          bad++; $display("FAIL bp_order_%0d: got %h required %h", got, obs(), exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
      @(posedge clk); #1;
      if (acc) bus.i_valid = 1'b0;
    end
    total++;
    if (got != 4 || exp_q.size() != 0) begin
      bad++; $display("FAIL bp_count: got %0d results required 4 (left %0d)", got, exp_q.size());
    end
    exp_q.delete();
  endtask

`ifdef FADD_SUB_EN
  task automatic test_sub();
    bit got;
    bus.o_ready = 1'b1;
    bus.i_sub = 1'b1;
    drive_op(15'h2000, 5'h00, 15'h2000, 5'h00);
    wait_valid(got);
    total++;
    if (!got || obs() !== {W{1'b0}}) begin
      bad++; $display("FAIL sub_zero: valid=%b got %h required 0", got, obs());
    end
    @(posedge clk); #1;
    bus.i_sub = 1'b1;
    drive_op(15'h2000, 5'h01, 15'h6000, 5'h00);
    wait_valid(got);
    total++;
    if (!got || obs() !== {15'h3000, 5'h01, 2'b00}) begin
      bad++; $display("FAIL sub_neg: valid=%b got %h required %h", got, obs(), {15'h3000, 5'h01, 2'b00});
    end
    @(posedge clk); #1;
    bus.i_sub = 1'b0;
  endtask
`endif

  task automatic test_reset_flight();
    int stale;
    stale = 0;
    bus.o_ready = 1'b0;
    drive_op(15'h2000, 5'h01, 15'h2000, 5'h00);
    drive_op(15'h3000, 5'h00, 15'h3000, 5'h00);
    @(posedge clk); #1;
    total++;
    if (bus.o_valid !== 1'b1) begin
      bad++; $display("FAIL flight_valid: o_valid=%b required 1", bus.o_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.o_valid, bus.i_ready, obs()} !== {2'b01, {W{1'b0}}}) begin
      bad++;
      $display("FAIL flight_reset: v=%b rdy=%b got %h required v=0 rdy=1 0",
               bus.o_valid, bus.i_ready, obs());
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    bus.o_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (bus.o_valid === 1'b1) stale++;
    end
    total++;
    if (stale != 0) begin
      bad++; $display("FAIL flight_stale: %0d results seen required 0", stale);
    end
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_mant1 = '0;
    bus.i_mant2 = '0;
    bus.i_exp1  = '0;
    bus.i_exp2  = '0;
    bus.o_ready = 1'b0;
`ifdef FADD_SUB_EN
    bus.i_sub   = 1'b0;
`endif
    test_reset();
    test_latency();
    test_arith();
    test_back_to_back();
    test_backpressure();
`ifdef FADD_SUB_EN
    test_sub();
`endif
    test_reset_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
